// File: rtl/tanimoto_pkg.sv
// Shared sizing helpers for the tanimoto ID-pair path: pair width, slots per
// bus word, slot-count width and slot bit offsets.
package tanimoto_pkg;

    function automatic int unsigned pair_w_f(input int unsigned vec_id_w);
        return 2 * vec_id_w;
    endfunction

    // At least one slot even if a pair is wider than the bus.
    function automatic int unsigned slots_f(input int unsigned bus_w, input int unsigned pair_w);
        return (bus_w / pair_w >= 1) ? bus_w / pair_w : 1;
    endfunction

    function automatic int unsigned cnt_w_f(input int unsigned slots);
        return $clog2(slots + 1);
    endfunction

    function automatic int unsigned slot_lsb_f(input int unsigned slot, input int unsigned pair_w);
        return slot * pair_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a registered
// pointer; the pointer advances past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int unsigned CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req_i,
    input  logic                en_i,
    output logic [CHANNELS-1:0] grant_c_o
);

    localparam int unsigned PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int          CH_I  = int'(CHANNELS);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found_c;

    always_comb begin
        grant_c_o = '0;
        ptr_d     = ptr_q;
        found_c   = 1'b0;
        for (int i = 0; i < CH_I; i++) begin
            for (int c = 0; c < CH_I; c++) begin
                if (!found_c && req_i[c] && (((int'(ptr_q) + i) % CH_I) == c)) begin
                    found_c      = 1'b1;
                    grant_c_o[c] = en_i;
                    if (en_i) begin
                        ptr_d = PTR_W'((c + 1) % CH_I);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/idpair_packer.sv
// Merges per-lane ID pairs into BUS_WIDTH words: round-robin lane pick, an
// accumulator that fills LSB-first, and a valid/ready output register.
module idpair_packer
    import tanimoto_pkg::*;
#(
    parameter  int unsigned CHANNELS     = 4,
    parameter  int unsigned VEC_ID_WIDTH = 10,
    parameter  int unsigned BUS_WIDTH    = 512,
    localparam int unsigned PAIR_W       = pair_w_f(VEC_ID_WIDTH),
    localparam int unsigned SLOTS        = slots_f(BUS_WIDTH, PAIR_W),
    localparam int unsigned CNT_W        = cnt_w_f(SLOTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          i_IDPair_Ready,
    input  logic [CHANNELS*PAIR_W-1:0]   i_IDPair,
    output logic [CHANNELS-1:0]          o_IDPair_Read,
    input  logic                         i_Flush,
    output logic                         o_Flush_Done,
    output logic                         o_Word_Valid,
    input  logic                         i_Word_Ready,
    output logic [BUS_WIDTH-1:0]         o_Word,
    output logic [CNT_W-1:0]             o_Word_Count
);

    logic [BUS_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     fill_q, fill_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 word_valid_q, word_valid_d;
    logic [BUS_WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 flush_done_q, flush_done_d;

    logic                 out_free_c, xfer_c, accept_en_c, accept_c, done_c;
    logic [PAIR_W-1:0]    pair_sel_c;
    logic [CHANNELS-1:0]  read_c;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (i_IDPair_Ready),
        .en_i      (accept_en_c),
        .grant_c_o (read_c)
    );

    assign o_IDPair_Read = read_c;
    assign o_Flush_Done  = flush_done_q;
    assign o_Word_Valid  = word_valid_q;
    assign o_Word        = word_q;
    assign o_Word_Count  = count_q;

    // Transfer/accept/flush-completion decisions for this cycle.
    always_comb begin
        out_free_c  = !word_valid_q || i_Word_Ready;
        xfer_c      = out_free_c &&
                      ((fill_q == CNT_W'(SLOTS)) || (flush_pend_q && (fill_q != '0)));
        accept_en_c = !rst && !flush_pend_q && ((fill_q != CNT_W'(SLOTS)) || xfer_c);
        done_c      = flush_pend_q && (xfer_c || (fill_q == '0));
        accept_c    = |read_c;
        pair_sel_c  = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (read_c[c]) begin
                pair_sel_c = pair_sel_c | i_IDPair[c*int'(PAIR_W) +: PAIR_W];
            end
        end
    end

    // Next state; the accumulator is cleared on transfer so unfilled slots read as zero.
    always_comb begin
        acc_d        = xfer_c ? '0 : acc_q;
        fill_d       = xfer_c ? '0 : fill_q;
        word_valid_d = word_valid_q;
        word_d       = word_q;
        count_d      = count_q;
        flush_pend_d = flush_pend_q ? !done_c : i_Flush;
        flush_done_d = done_c;

        if (accept_c) begin
            for (int s = 0; s < int'(SLOTS); s++) begin
                if (fill_d == CNT_W'(s)) begin
                    acc_d[slot_lsb_f(s, PAIR_W) +: PAIR_W] = pair_sel_c;
                end
            end
            fill_d = fill_d + CNT_W'(1);
        end

        if (xfer_c) begin
            word_valid_d = 1'b1;
            word_d       = acc_q;
            count_d      = fill_q;
        end else if (word_valid_q && i_Word_Ready) begin
            word_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            fill_q       <= '0;
            flush_pend_q <= 1'b0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
            count_q      <= '0;
            flush_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            flush_pend_q <= flush_pend_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
            count_q      <= count_d;
            flush_done_q <= flush_done_d;
        end
    end

endmodule

// File: tb/tb_idpair_packer.sv
// Directed bench for idpair_packer: lanes are modelled as counters of pending
// pairs, accepted words are captured and compared to hand-derived contents.
module tb_idpair_packer;

    localparam int CH = 4;
    localparam int PW = 20;
    localparam int BW = 512;
    localparam int SL = 25;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     i_IDPair_Ready;
    logic [CH*PW-1:0]  i_IDPair;
    logic [CH-1:0]     o_IDPair_Read;
    logic              i_Flush;
    logic              o_Flush_Done;
    logic              o_Word_Valid;
    logic              i_Word_Ready;
    logic [BW-1:0]     o_Word;
    logic [CW-1:0]     o_Word_Count;

    int                total = 0;
    int                bad   = 0;
    int                lane_left [CH];
    int                lane_next [CH];
    int                grant_log [$];
    logic [BW-1:0]     words [$];
    logic [CW-1:0]     counts [$];
    int                valid_cycles, done_pulses, read_gaps;
    logic [CH-1:0]     last_read;

    idpair_packer dut (
        .clk            (clk),
        .rst            (rst),
        .i_IDPair_Ready (i_IDPair_Ready),
        .i_IDPair       (i_IDPair),
        .o_IDPair_Read  (o_IDPair_Read),
        .i_Flush        (i_Flush),
        .o_Flush_Done   (o_Flush_Done),
        .o_Word_Valid   (o_Word_Valid),
        .i_Word_Ready   (i_Word_Ready),
        .o_Word         (o_Word),
        .o_Word_Count   (o_Word_Count)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pv(input int c, input int n);
        return PW'((c << 16) | n);
    endfunction

    // Word built from lane 0 pairs 1..n in slots 0..n-1.
    function automatic logic [BW-1:0] exp_seq_word(input int n);
        logic [BW-1:0] w;
        w = '0;
        for (int s = 0; s < n; s++) w[s*PW +: PW] = pv(0, s + 1);
        return w;
    endfunction

    // Word w of the stream produced by four always-ready lanes granted 0,1,2,3,...
    function automatic logic [BW-1:0] exp_rr_word(input int w);
        logic [BW-1:0] r;
        int            i;
        r = '0;
        for (int s = 0; s < SL; s++) begin
            i = w * SL + s;
            r[s*PW +: PW] = pv(i % CH, i / CH + 1);
        end
        return r;
    endfunction

    task automatic cycle();
        for (int c = 0; c < CH; c++) begin
            i_IDPair_Ready[c]    = (lane_left[c] > 0);
            i_IDPair[c*PW +: PW] = pv(c, lane_next[c]);
        end
        #1;
        last_read = o_IDPair_Read;
        if (last_read == '0) read_gaps++;
        for (int c = 0; c < CH; c++) begin
            if (last_read[c]) begin
                grant_log.push_back(c);
                lane_left[c]--;
                lane_next[c]++;
            end
        end
        if (o_Word_Valid) valid_cycles++;
        if (o_Word_Valid && i_Word_Ready) begin
            words.push_back(o_Word);
            counts.push_back(o_Word_Count);
        end
        if (o_Flush_Done) done_pulses++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        words.delete();
        counts.delete();
        valid_cycles = 0;
        done_pulses  = 0;
        read_gaps    = 0;
    endtask

    task automatic set_lanes(input int n);
        for (int c = 0; c < CH; c++) begin
            lane_left[c] = n;
            lane_next[c] = 1;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        i_Flush      = 1'b0;
        i_Word_Ready = 1'b1;
        set_lanes(0);
        cycle();
        cycle();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        i_Flush      = 1'b0;
        i_Word_Ready = 1'b1;
        set_lanes(5);
        cycle();
        total++; if (last_read !== '0) begin bad++; $display("FAIL reset_read got=%0h exp=0", last_read); end
        cycle();
        total++; if (o_Word_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", o_Word_Valid); end
        total++; if (o_Word !== '0) begin bad++; $display("FAIL reset_word got=%0h exp=0", o_Word); end
        total++; if (o_Word_Count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_Word_Count); end
        total++; if (o_Flush_Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", o_Flush_Done); end
        total++; if (last_read !== '0) begin bad++; $display("FAIL reset_read2 got=%0h exp=0", last_read); end
        rst = 1'b0;
        set_lanes(0);
        clear_logs();
    endtask

    task automatic test_single_lane();
        do_reset();
        lane_left[0] = SL;
        repeat (SL) cycle();
        total++; if (grant_log.size() !== SL) begin bad++; $display("FAIL single_grants got=%0d exp=%0d", grant_log.size(), SL); end
        total++; if (o_Word_Valid !== 1'b0) begin bad++; $display("FAIL single_valid_early got=%0b exp=0", o_Word_Valid); end
        cycle();
        total++; if (o_Word_Valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", o_Word_Valid); end
        total++; if (o_Word_Count !== CW'(SL)) begin bad++; $display("FAIL single_count got=%0d exp=%0d", o_Word_Count, SL); end
        total++; if (o_Word !== exp_seq_word(SL)) begin bad++; $display("FAIL single_word got=%0h exp=%0h", o_Word, exp_seq_word(SL)); end
        total++; if (o_Word[511:500] !== 12'h000) begin bad++; $display("FAIL single_top_bits got=%0h exp=0", o_Word[511:500]); end
        cycle();
        total++; if (o_Word_Valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%0b exp=0", o_Word_Valid); end
        total++; if (valid_cycles !== 1) begin bad++; $display("FAIL single_valid_cycles got=%0d exp=1", valid_cycles); end
    endtask

    task automatic test_round_robin();
        int order_err;
        do_reset();
        set_lanes(SL);
        repeat (4 * SL) cycle();
        order_err = 0;
        foreach (grant_log[i]) if (grant_log[i] != i % CH) order_err++;
        total++; if (grant_log.size() !== 4 * SL) begin bad++; $display("FAIL rr_grants got=%0d exp=%0d", grant_log.size(), 4 * SL); end
        total++; if (order_err !== 0) begin bad++; $display("FAIL rr_order got=%0d exp=0 wrong grants", order_err); end
        total++; if (read_gaps !== 0) begin bad++; $display("FAIL rr_gaps got=%0d exp=0", read_gaps); end
        repeat (2) cycle();
        total++; if (words.size() !== 4) begin bad++; $display("FAIL rr_words got=%0d exp=4", words.size()); end
        for (int w = 0; w < 4; w++) begin
            if (w < words.size()) begin
                total++; if (words[w] !== exp_rr_word(w)) begin bad++; $display("FAIL rr_word%0d got=%0h exp=%0h", w, words[w], exp_rr_word(w)); end
                total++; if (counts[w] !== CW'(SL)) begin bad++; $display("FAIL rr_count%0d got=%0d exp=%0d", w, counts[w], SL); end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        lane_left[0] = 20;
        repeat (7) cycle();
        i_Flush = 1'b1;
        cycle();
        i_Flush = 1'b0;
        total++; if (last_read !== 4'b0001) begin bad++; $display("FAIL flush_same_cycle_read got=%0h exp=1", last_read); end
        cycle();
        total++; if (last_read !== '0) begin bad++; $display("FAIL flush_pending_read got=%0h exp=0", last_read); end
        total++; if (o_Word_Valid !== 1'b1) begin bad++; $display("FAIL flush_valid got=%0b exp=1", o_Word_Valid); end
        total++; if (o_Flush_Done !== 1'b1) begin bad++; $display("FAIL flush_done got=%0b exp=1", o_Flush_Done); end
        total++; if (o_Word_Count !== CW'(8)) begin bad++; $display("FAIL flush_count got=%0d exp=8", o_Word_Count); end
        total++; if (o_Word !== exp_seq_word(8)) begin bad++; $display("FAIL flush_word got=%0h exp=%0h", o_Word, exp_seq_word(8)); end
        cycle();
        total++; if (o_Flush_Done !== 1'b0) begin bad++; $display("FAIL flush_done_pulse got=%0b exp=0", o_Flush_Done); end
        total++; if (last_read !== 4'b0001) begin bad++; $display("FAIL flush_resume_read got=%0h exp=1", last_read); end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] hold;
        do_reset();
        i_Word_Ready = 1'b0;
        set_lanes(SL);
        repeat (30) cycle();
        hold = o_Word;
        repeat (30) cycle();
        total++; if (grant_log.size() !== 2 * SL) begin bad++; $display("FAIL bp_grants got=%0d exp=%0d", grant_log.size(), 2 * SL); end
        total++; if (last_read !== '0) begin bad++; $display("FAIL bp_read_stalled got=%0h exp=0", last_read); end
        total++; if (o_Word_Valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%0b exp=1", o_Word_Valid); end
        total++; if (o_Word !== hold) begin bad++; $display("FAIL bp_stable got=%0h exp=%0h", o_Word, hold); end
        total++; if (hold !== exp_rr_word(0)) begin bad++; $display("FAIL bp_held_word got=%0h exp=%0h", hold, exp_rr_word(0)); end
        i_Word_Ready = 1'b1;
        repeat (60) cycle();
        total++; if (grant_log.size() !== 4 * SL) begin bad++; $display("FAIL bp_grants_total got=%0d exp=%0d", grant_log.size(), 4 * SL); end
        total++; if (words.size() !== 4) begin bad++; $display("FAIL bp_words got=%0d exp=4", words.size()); end
        for (int w = 0; w < 4; w++) begin
            if (w < words.size()) begin
                total++; if (words[w] !== exp_rr_word(w)) begin bad++; $display("FAIL bp_word%0d got=%0h exp=%0h", w, words[w], exp_rr_word(w)); end
            end
        end
    endtask

    task automatic test_flush_empty();
        do_reset();
        i_Flush = 1'b1;
        cycle();
        i_Flush = 1'b0;
        total++; if (o_Flush_Done !== 1'b0) begin bad++; $display("FAIL fe_done_early got=%0b exp=0", o_Flush_Done); end
        cycle();
        total++; if (o_Flush_Done !== 1'b1) begin bad++; $display("FAIL fe_done got=%0b exp=1", o_Flush_Done); end
        total++; if (o_Word_Valid !== 1'b0) begin bad++; $display("FAIL fe_valid got=%0b exp=0", o_Word_Valid); end
        cycle();
        total++; if (o_Flush_Done !== 1'b0) begin bad++; $display("FAIL fe_done_pulse got=%0b exp=0", o_Flush_Done); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lane_left[2] = 12;
        repeat (12) cycle();
        i_Flush = 1'b1;
        cycle();
        i_Flush = 1'b0;
        rst = 1'b1;
        set_lanes(SL);
        cycle();
        rst = 1'b0;
        total++; if (last_read !== '0) begin bad++; $display("FAIL rm_read got=%0h exp=0", last_read); end
        total++; if (o_Word_Valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0b exp=0", o_Word_Valid); end
        total++; if (o_Flush_Done !== 1'b0) begin bad++; $display("FAIL rm_done got=%0b exp=0", o_Flush_Done); end
        total++; if (o_Word !== '0) begin bad++; $display("FAIL rm_word got=%0h exp=0", o_Word); end
        clear_logs();
        repeat (SL + 1) cycle();
        total++; if (grant_log.size() == 0 || grant_log[0] != 0) begin bad++; $display("FAIL rm_first_grant got=%0d exp=0", (grant_log.size() == 0) ? -1 : grant_log[0]); end
        total++; if (done_pulses !== 0) begin bad++; $display("FAIL rm_done_pulses got=%0d exp=0", done_pulses); end
        total++; if (o_Word_Valid !== 1'b1) begin bad++; $display("FAIL rm_next_valid got=%0b exp=1", o_Word_Valid); end
        total++; if (o_Word_Count !== CW'(SL)) begin bad++; $display("FAIL rm_next_count got=%0d exp=%0d", o_Word_Count, SL); end
        total++; if (o_Word !== exp_rr_word(0)) begin bad++; $display("FAIL rm_next_word got=%0h exp=%0h", o_Word, exp_rr_word(0)); end
    endtask

    initial begin
        rst            = 1'b1;
        i_Flush        = 1'b0;
        i_Word_Ready   = 1'b1;
        i_IDPair_Ready = '0;
        i_IDPair       = '0;
        set_lanes(0);
        clear_logs();
        test_reset();
        test_single_lane();
        test_round_robin();
        test_flush();
        test_backpressure();
        test_flush_empty();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idpair_packer.md
Name: idpair_packer

Overview:
- Merges ID-pair streams from CHANNELS parallel tanimoto compare lanes into one stream.
- Each lane is a top_cnt1-style instance with ready/read ID-pair output.
- Arbitrates lanes round-robin and packs accepted pairs LSB-first into BUS_WIDTH words for host writeback.
- Supports an explicit flush that emits a partially filled word, tagged with its valid-pair count.

Parameters:
- CHANNELS, 4, number of compare lanes feeding the packer (1..16).
- VEC_ID_WIDTH, 10, width of one vector ID; PAIR_W = 2*VEC_ID_WIDTH.
- BUS_WIDTH, 512, output word width; SLOTS = BUS_WIDTH / PAIR_W (floor, >= 1).
- CNT_W, derived, $clog2(SLOTS+1), width of the slot count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- i_IDPair_Ready  in  CHANNELS  lane c holds a valid pair on its slice of i_IDPair.
- i_IDPair  in  CHANNELS*PAIR_W  lane c pair at bits [c*PAIR_W +: PAIR_W].
- o_IDPair_Read  out  CHANNELS  one-hot or zero; lane c pops its pair this cycle.
- i_Flush  in  1  request emission of the partial word.
- o_Flush_Done  out  1  one-cycle pulse when the flush completes.
- o_Word_Valid  out  1  o_Word / o_Word_Count are valid.
- i_Word_Ready  in  1  downstream accepts the word.
- o_Word  out  BUS_WIDTH  packed pairs; slot s at [s*PAIR_W +: PAIR_W]; unused bits 0.
- o_Word_Count  out  CNT_W  number of valid slots (1..SLOTS).

Behaviour:
- Reset (sync, active-high) clears: o_Word_Valid, o_Word, o_Word_Count, o_Flush_Done, accumulator, fill counter, flush-pending flag; RR pointer = 0.
- o_IDPair_Read is combinational from i_IDPair_Ready and state; all other outputs are registered.
- Storage is an accumulator register (fill 0..SLOTS) plus one output register (valid/ready, double buffer).
- Transfer fires when the output register is free and either fill==SLOTS, or flush is pending with fill>0.
  - Output register is free when !o_Word_Valid, or o_Word_Valid & i_Word_Ready.
  - Transfer copies accumulator to o_Word (unfilled slots zeroed) and fill to o_Word_Count.
  - Same edge: o_Word_Valid=1 and fill resets to 0.
- Accept is enabled when !flush_pending and (fill<SLOTS, or a transfer fires this cycle).
- Grant: first lane with Ready set, searching from the RR pointer upward with wrap.
  - o_IDPair_Read[grant] asserts only if accept is enabled; at most one pair is accepted per cycle.
  - Accepted pair is written at slot fill; on a same-cycle transfer it goes to slot 0 of the emptied accumulator.
  - After a grant to lane k, the pointer becomes (k+1) mod CHANNELS; the pointer is unchanged when nothing is granted.
- Latency: the pair filling slot SLOTS-1 at edge t is visible on o_Word at edge t+1 if the output register is free.
- Sustained throughput with i_Word_Ready=1 is 1 pair/cycle.
- Output register: o_Word, o_Word_Count and o_Word_Valid hold stable while o_Word_Valid & !i_Word_Ready.
  - If not reloaded, o_Word_Valid drops on the edge after acceptance.
- Flush:
  - i_Flush sets flush_pending. A pair accepted in the same cycle as i_Flush is included in the flushed word.
  - While pending, no lane is read.
  - Flush completes on the edge where the partial word transfers. If fill==0 when flush is seen, it completes on the next edge.
  - Completion: o_Flush_Done pulses 1 cycle and flush_pending clears.
  - i_Flush while already pending is ignored.
  - A full word (fill==SLOTS) at flush time transfers normally with count SLOTS.
- Reset mid-word or mid-flush: partial data is discarded, no o_Flush_Done, no lane read in that cycle.

Decomposition:
- Package tanimoto_pkg holds PAIR_W, SLOTS and CNT_W derivation functions and the slot-index helper.
- These are shared with top_cnt1 wrappers and the host-side unpacker model.
- Sub-module rr_arbiter (CHANNELS-wide, req/enable/grant one-hot, registered pointer, sync active-high rst).
- The packer instantiates one rr_arbiter; accumulator, output register and flush logic stay in idpair_packer.

Test Plan:
Defaults: PAIR_W=20, SLOTS=25, CNT_W=5.
1. Lane 0 only, 25 pairs 0x00001..0x00019, i_Word_Ready=1 -> one word, count 25, slot s = s+1, bits[511:500]=0, Valid exactly 1 cycle.
2. All 4 lanes ready continuously, pointer starts at 0 -> grant order 0,1,2,3,0,...; 100 pairs produce 4 words of count 25, no gaps in o_IDPair_Read.
3. 7 pairs then i_Flush=1 with a pair accepted that cycle -> word count 8 (slots 8..24 zero), o_Flush_Done the same edge as Valid rises; no lane read while pending.
4. i_Word_Ready=0 for 60 cycles under full load -> second word stays in the accumulator, o_IDPair_Read=0 after 50 pairs, o_Word stable; on Ready=1 both words drain in order with no loss or duplication.
5. i_Flush with fill=0 and empty output -> o_Flush_Done pulses next edge, o_Word_Valid stays 0.
6. rst=1 for 1 cycle with fill=12 and flush pending -> all outputs 0, pointer 0, next word starts at slot 0, no Flush_Done.
